// File: rtl/rram_mux_blwl_prog_ctrl_if.sv
// rram_mux_blwl_prog_ctrl_if: configuration request/status bundle for the RRAM MUX programming sequencer
//   cfg_valid/cfg_ready : request handshake, accepted when both are high on a posedge
//   cfg_sel             : MUX input index to connect to out
//   cfg_skip_rst        : skip the reset-all phase for this request
//   busy/done/cfg_err   : sequence status, completion pulse, rejection pulse
interface rram_mux_blwl_prog_ctrl_if #(
    parameter int SEL_WIDTH = 2
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [SEL_WIDTH-1:0] cfg_sel;
    logic                 cfg_skip_rst;
    logic                 busy;
    logic                 done;
    logic                 cfg_err;

    modport master (
        output cfg_valid, cfg_sel, cfg_skip_rst,
        input  cfg_ready, busy, done, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_sel, cfg_skip_rst,
        output cfg_ready, busy, done, cfg_err
    );
endinterface

// File: rtl/rram_mux_blwl_prog_ctrl.sv
// rram_mux_blwl_prog_ctrl: sequences reset-all then set-selected programming pulses for a 4T1R 1-level RRAM MUX
//   prog_clock/prog_resetb : clock, asynchronous active-low reset
//   cfg                    : request handshake and status (slave side)
//   prog_EN/prog_ENb       : programming enable and its complement
//   bl/wl                  : bit-line / word-line drive, index SIZE_OF_MUX is the output-side line
module rram_mux_blwl_prog_ctrl #(
    parameter int SIZE_OF_MUX  = 4,
    parameter int SIZE_OF_BLWL = SIZE_OF_MUX + 1,
    parameter int SEL_WIDTH    = 2,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                    prog_clock,
    input  logic                    prog_resetb,
    rram_mux_blwl_prog_ctrl_if.slave cfg,
    output logic                    prog_EN,
    output logic                    prog_ENb,
    output logic [0:SIZE_OF_BLWL-1] bl,
    output logic [0:SIZE_OF_BLWL-1] wl
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RST_PULSE = 3'd1;
    localparam logic [2:0] S_RST_GAP   = 3'd2;
    localparam logic [2:0] S_SET_PULSE = 3'd3;
    localparam logic [2:0] S_SET_GAP   = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    localparam int MAXC = PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam int JW   = $clog2(SIZE_OF_MUX);
    localparam int IW   = $clog2(SIZE_OF_BLWL);

    logic [2:0]                state, state_n;
    logic [CW-1:0]             cnt, cnt_n;
    logic [JW-1:0]             j, j_n;
    logic [SEL_WIDTH-1:0]      sel, sel_n;
    logic                      err_n, en_n;
    logic [0:SIZE_OF_BLWL-1]   bl_n, wl_n;

    wire pulse_end = cnt == CW'(PULSE_CYCLES - 1);
    wire gap_end   = cnt == CW'(GAP_CYCLES - 1);
    wire sel_ok    = {1'b0, cfg.cfg_sel} < (SEL_WIDTH + 1)'(SIZE_OF_MUX);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        j_n     = j;
        sel_n   = sel;
        err_n   = 1'b0;
        case (state)
            S_IDLE: if (cfg.cfg_valid) begin
                err_n = !sel_ok;
                if (sel_ok) begin
                    sel_n   = cfg.cfg_sel;
                    j_n     = '0;
                    cnt_n   = '0;
                    state_n = cfg.cfg_skip_rst ? S_SET_PULSE : S_RST_PULSE;
                end
            end
            S_RST_PULSE: begin
                cnt_n   = pulse_end ? '0 : cnt + CW'(1);
                state_n = pulse_end ? S_RST_GAP : S_RST_PULSE;
            end
            S_RST_GAP: if (gap_end) begin
                cnt_n   = '0;
                // last input already reset: move on to the set phase
                state_n = j == JW'(SIZE_OF_MUX - 1) ? S_SET_PULSE : S_RST_PULSE;
                j_n     = j == JW'(SIZE_OF_MUX - 1) ? j : j + JW'(1);
            end else begin
                cnt_n = cnt + CW'(1);
            end
            S_SET_PULSE: begin
                cnt_n   = pulse_end ? '0 : cnt + CW'(1);
                state_n = pulse_end ? S_SET_GAP : S_SET_PULSE;
            end
            S_SET_GAP: begin
                cnt_n   = gap_end ? '0 : cnt + CW'(1);
                state_n = gap_end ? S_DONE : S_SET_GAP;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // line drive is decoded from the next state so every output leaves a register
    always_comb begin
        bl_n = '0;
        wl_n = '0;
        en_n = state_n == S_RST_PULSE || state_n == S_SET_PULSE;
        if (state_n == S_RST_PULSE) begin
            wl_n[IW'(j_n)]     = 1'b1;
            bl_n[SIZE_OF_MUX]  = 1'b1;
        end
        if (state_n == S_SET_PULSE) begin
            bl_n[IW'(sel_n)]   = 1'b1;
            wl_n[SIZE_OF_MUX]  = 1'b1;
        end
    end

    always_ff @(posedge prog_clock or negedge prog_resetb) begin
        if (!prog_resetb) begin
            state         <= S_IDLE;
            cnt           <= '0;
            j             <= '0;
            sel           <= '0;
            bl            <= '0;
            wl            <= '0;
            prog_EN       <= 1'b0;
            prog_ENb      <= 1'b1;
            cfg.busy      <= 1'b0;
            cfg.done      <= 1'b0;
            cfg.cfg_err   <= 1'b0;
            cfg.cfg_ready <= 1'b1;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            j             <= j_n;
            sel           <= sel_n;
            bl            <= bl_n;
            wl            <= wl_n;
            prog_EN       <= en_n;
            prog_ENb      <= !en_n;
            cfg.busy      <= state_n != S_IDLE;
            cfg.done      <= state_n == S_DONE;
            cfg.cfg_err   <= err_n;
            cfg.cfg_ready <= state_n == S_IDLE;
        end
    end
endmodule

// File: tb/tb_rram_mux_blwl_prog_ctrl.sv
// tb_rram_mux_blwl_prog_ctrl: randomized self-checking bench for rram_mux_blwl_prog_ctrl against a pulse-list model
module tb_rram_mux_blwl_prog_ctrl;
    localparam int N = 4, BLWL = N + 1, P = 2, G = 1;

    typedef struct {
        logic [0:BLWL-1] bl;
        logic [0:BLWL-1] wl;
        logic            en;
        logic            done;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstb;
    logic            en, enb, en3, enb3;
    logic [0:BLWL-1] bl, wl;
    logic [0:3]      bl3, wl3;
    int              errors = 0, checks = 0;
    logic            mon_on = 1'b0;
    exp_t            q[$];

    rram_mux_blwl_prog_ctrl_if #(.SEL_WIDTH(2)) cfg ();
    rram_mux_blwl_prog_ctrl_if #(.SEL_WIDTH(2)) cfg3 ();

    rram_mux_blwl_prog_ctrl dut (
        .prog_clock(clk), .prog_resetb(rstb), .cfg(cfg),
        .prog_EN(en), .prog_ENb(enb), .bl(bl), .wl(wl)
    );

    rram_mux_blwl_prog_ctrl #(.SIZE_OF_MUX(3)) dut3 (
        .prog_clock(clk), .prog_resetb(rstb), .cfg(cfg3),
        .prog_EN(en3), .prog_ENb(enb3), .bl(bl3), .wl(wl3)
    );

    function automatic logic [0:BLWL-1] oh(input int i);
        logic [0:BLWL-1] v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // expected per-cycle line activity after an accept: reset every input, set the chosen one, then done
    function automatic void build(input int s, input bit skip);
        q.delete();
        if (!skip)
            for (int i = 0; i < N; i++) begin
                repeat (P) q.push_back('{oh(N), oh(i), 1'b1, 1'b0});
                repeat (G) q.push_back('{'0, '0, 1'b0, 1'b0});
            end
        repeat (P) q.push_back('{oh(s), oh(N), 1'b1, 1'b0});
        repeat (G) q.push_back('{'0, '0, 1'b0, 1'b0});
        q.push_back('{'0, '0, 1'b0, 1'b1});
    endfunction

    always @(negedge clk) if (mon_on) begin
        checks++;
        if ($countones(bl) > 1 || $countones(wl) > 1 || ((bl | wl) != '0 && en !== 1'b1) || enb !== ~en) begin
            errors++;
            $display("FAIL invariant t=%0t bl=%b wl=%b en=%b enb=%b", $time, bl, wl, en, enb);
        end
    end

    task automatic run_seq(input int s, input bit sk, input bit hold, input int ns);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_sel = 2'(s);
        cfg.cfg_skip_rst = sk;
        build(s, sk);
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            if (k == 0) begin
                if (hold) cfg.cfg_sel = 2'(ns);
                else cfg.cfg_valid = 1'b0;
            end
            checks++;
            if ({bl, wl, en, cfg.done, cfg.busy, cfg.cfg_ready} !== {q[k].bl, q[k].wl, q[k].en, q[k].done, 2'b10}) begin
                errors++;
                $display("FAIL seq sel=%0d skip=%0d cycle=%0d got bl=%b wl=%b en=%b done=%b busy=%b rdy=%b want bl=%b wl=%b en=%b done=%b busy=1 rdy=0",
                         s, sk, k + 1, bl, wl, en, cfg.done, cfg.busy, cfg.cfg_ready, q[k].bl, q[k].wl, q[k].en, q[k].done);
            end
        end
        @(negedge clk);
        checks++;
        if ({cfg.cfg_ready, cfg.busy, cfg.done, en, bl, wl} !== {4'b1000, {2 * BLWL{1'b0}}}) begin
            errors++;
            $display("FAIL idle_after sel=%0d got rdy=%b busy=%b done=%b en=%b bl=%b wl=%b want rdy=1 rest 0",
                     s, cfg.cfg_ready, cfg.busy, cfg.done, en, bl, wl);
        end
    endtask

    task automatic test_reset();
        #2 rstb = 1'b0;
        #1;
        checks++;
        if ({bl, wl, en, enb, cfg.busy, cfg.done, cfg.cfg_err} !== {{2 * BLWL{1'b0}}, 5'b01000}) begin
            errors++;
            $display("FAIL reset_hold got bl=%b wl=%b en=%b enb=%b busy=%b done=%b err=%b want 0 with enb=1",
                     bl, wl, en, enb, cfg.busy, cfg.done, cfg.cfg_err);
        end
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        checks++;
        if ({cfg.cfg_ready, cfg.busy, en, enb} !== 4'b1001) begin
            errors++;
            $display("FAIL reset_release got rdy=%b busy=%b en=%b enb=%b want 1 0 0 1", cfg.cfg_ready, cfg.busy, en, enb);
        end
        mon_on = 1'b1;
    endtask

    task automatic test_full();
        run_seq(0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_skip();
        run_seq(3, 1'b1, 1'b0, 0);
    endtask

    task automatic test_err();
        cfg3.cfg_valid = 1'b1;
        cfg3.cfg_sel = 2'd3;
        cfg3.cfg_skip_rst = 1'b0;
        @(negedge clk);
        cfg3.cfg_valid = 1'b0;
        checks++;
        if ({cfg3.cfg_err, cfg3.cfg_ready, cfg3.busy, en3, bl3, wl3} !== {4'b1100, 8'h00}) begin
            errors++;
            $display("FAIL err_pulse got err=%b rdy=%b busy=%b en=%b bl=%b wl=%b want err=1 rdy=1 rest 0",
                     cfg3.cfg_err, cfg3.cfg_ready, cfg3.busy, en3, bl3, wl3);
        end
        @(negedge clk);
        checks++;
        if ({cfg3.cfg_err, cfg3.cfg_ready} !== 2'b01) begin
            errors++;
            $display("FAIL err_clear got err=%b rdy=%b want 0 1", cfg3.cfg_err, cfg3.cfg_ready);
        end
        cfg3.cfg_valid = 1'b1;
        cfg3.cfg_sel = 2'd2;
        cfg3.cfg_skip_rst = 1'b1;
        @(negedge clk);
        cfg3.cfg_valid = 1'b0;
        checks++;
        if ({bl3, wl3, en3} !== {4'b0010, 4'b0001, 1'b1}) begin
            errors++;
            $display("FAIL n3_set got bl=%b wl=%b en=%b want 0010 0001 1", bl3, wl3, en3);
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({cfg3.cfg_ready, cfg3.busy} !== 2'b10) begin
            errors++;
            $display("FAIL n3_idle got rdy=%b busy=%b want 1 0", cfg3.cfg_ready, cfg3.busy);
        end
    endtask

    task automatic test_abort();
        cfg.cfg_valid = 1'b1;
        cfg.cfg_sel = 2'd0;
        cfg.cfg_skip_rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) cfg.cfg_valid = 1'b0;
        end
        checks++;
        if ({bl, wl, en} !== {oh(N), oh(2), 1'b1}) begin
            errors++;
            $display("FAIL abort_pre got bl=%b wl=%b en=%b want bl=%b wl=%b en=1", bl, wl, en, oh(N), oh(2));
        end
        #2 rstb = 1'b0;
        #1;
        checks++;
        if ({bl, wl, en, enb, cfg.busy, cfg.done} !== {{2 * BLWL{1'b0}}, 4'b0100}) begin
            errors++;
            $display("FAIL abort_async got bl=%b wl=%b en=%b enb=%b busy=%b done=%b want 0 with enb=1",
                     bl, wl, en, enb, cfg.busy, cfg.done);
        end
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if ({cfg.done, cfg.cfg_ready, cfg.busy} !== 3'b010) begin
                errors++;
                $display("FAIL abort_after cycle=%0d got done=%b rdy=%b busy=%b want 0 1 0", k, cfg.done, cfg.cfg_ready, cfg.busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_seq(1, 1'b0, 1'b1, 2);
        run_seq(2, 1'b0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_seq(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), 1'b0, 0);
        end
    endtask

    initial begin
        rstb = 1'b1;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_sel = '0;
        cfg.cfg_skip_rst = 1'b0;
        cfg3.cfg_valid = 1'b0;
        cfg3.cfg_sel = '0;
        cfg3.cfg_skip_rst = 1'b0;
        test_reset();
        test_full();
        test_skip();
        test_err();
        test_abort();
        test_back_to_back();
        test_random();
        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
